cam_alloc_ctrl: RTL and testbench
=================================

Name: cam_alloc_ctrl

Overview:
Sequences all lookups and updates to a shared CAM instance, so requesters never write it directly. It serializes insert, invalidate and flush requests. It keeps a shadow valid vector and picks a victim slot: lowest free index first, otherwise round-robin. This guarantees the CAM never holds duplicate keys. It sits between a tag/TLB fill unit and the CAM update and lookup ports.

Parameters:
NUM_ENTRIES, 8, number of CAM slots (any value >= 2)
KEY_WIDTH, 32, key width; must match the CAM
INDEX_WIDTH, $clog2(NUM_ENTRIES), slot index width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_op  input  2  00 insert, 01 invalidate, 10 flush-all, 11 reserved
req_key  input  KEY_WIDTH  key for insert/invalidate
req_ready  output  1  controller can accept a request this cycle
resp_valid  output  1  one-cycle completion pulse
resp_hit  output  1  key was already present (insert/invalidate)
resp_idx  output  INDEX_WIDTH  slot hit, written, or cleared
resp_evict  output  1  insert overwrote a valid entry
occupancy  output  INDEX_WIDTH+1  count of valid slots
cam_lookup_key  output  KEY_WIDTH  to CAM lookup port
cam_lookup_hit  input  1  CAM hit (combinational from cam_lookup_key)
cam_lookup_idx  input  INDEX_WIDTH  CAM hit index
cam_update_en, cam_update_valid  output  1 each  CAM update strobe and valid bit
cam_update_key  output  KEY_WIDTH  CAM update key
cam_update_idx  output  INDEX_WIDTH  CAM update index

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; shadow valid vector and occupancy clear to 0; rr_ptr resets to 0.
  - resp_valid, resp_hit, resp_evict, resp_idx reset to 0; cam_update_en resets to 0.
  - The CAM shares the same reset, so both sides come out empty. Reset mid-operation abandons the request with no response.
- States: IDLE, LOOKUP, FLUSH.
- IDLE:
  - req_ready=1; a request is accepted when req_valid && req_ready.
  - On accept, op and key are registered. Ops 00/01 go to LOOKUP; op 10 goes to FLUSH with walk counter 0.
  - Reserved op 11 stays in IDLE and pulses resp_valid next cycle with resp_hit=0, resp_evict=0, resp_idx=0.
- req_ready=0 in LOOKUP and FLUSH.
- LOOKUP (exactly one cycle): cam_lookup_key = registered key; the CAM result is used combinationally.
  - Insert, hit: no update; resp_hit=1, resp_idx=cam_lookup_idx.
  - Insert, miss: cam_update_en=1, cam_update_valid=1, cam_update_key=key.
    - Victim is the lowest index with shadow valid 0. If all slots are valid, the victim is rr_ptr, resp_evict=1, and rr_ptr advances by 1, wrapping NUM_ENTRIES-1 -> 0.
    - Shadow valid[victim] is set; resp_idx=victim, resp_hit=0.
  - Invalidate, hit: cam_update_en=1, cam_update_valid=0, cam_update_idx=cam_lookup_idx, cam_update_key=0. Clear shadow valid; resp_hit=1.
  - Invalidate, miss: no update; resp_hit=0, resp_idx=0.
  - Next state is IDLE; resp_* are registered and resp_valid pulses on the following cycle.
  - Latency is accept edge -> resp_valid 2 cycles; a new request can be accepted in the cycle resp_valid is high. Throughput is 1 request per 2 cycles.
- FLUSH:
  - Each cycle drives cam_update_en=1, cam_update_valid=0, cam_update_idx=walk counter, key=0, and the counter increments.
  - After slot NUM_ENTRIES-1, clear the shadow vector, keep rr_ptr, go to IDLE, and pulse resp_valid with resp_hit=0.
  - Total: NUM_ENTRIES update cycles, response one cycle after the last.
- occupancy = popcount(shadow valid), registered and updated on the same edge as the shadow vector. It never exceeds NUM_ENTRIES.
- cam_update_en is 0 in every cycle not listed above. cam_lookup_key holds the registered key otherwise.
- Invariant: the CAM never receives a valid update for a key already present in another slot.

Test Plan:
- Reset, then insert 0x1000 -> resp_valid 2 cycles after accept, resp_hit=0, resp_idx=0, occupancy=1; CAM lookup of 0x1000 hits at index 0.
- Insert 0x1000 again -> resp_hit=1, resp_idx=0, no cam_update_en pulse, occupancy stays 1.
- NUM_ENTRIES=8: insert 0x10..0x80 to fill 0-7; insert 0x90 -> resp_idx=0, resp_evict=1. Insert 0xA0 -> resp_idx=1, resp_evict=1; 0x10 now misses.
- Invalidate 0x30 (slot 2) -> resp_hit=1, resp_idx=2, occupancy 7. The next insert 0xB0 -> resp_idx=2, resp_evict=0.
- Flush -> 8 consecutive cam_update_en cycles with idx 0..7, valid=0; then resp_valid, occupancy=0, all lookups miss.
- Assert reset during FLUSH at idx 3 -> no resp_valid, req_ready=1, occupancy=0 after reset. Op 11 -> resp_valid with resp_hit=0 and no CAM update.

Source files
------------

// File: rtl/cam_alloc_ctrl_if.sv
// Request/response, occupancy and CAM lookup/update signals of the CAM allocation controller.
// slave = the controller; master = the fill unit plus the CAM it fronts.
interface cam_alloc_ctrl_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
);
  logic                   req_valid;
  logic [1:0]             req_op;
  logic [KEY_WIDTH-1:0]   req_key;
  logic                   req_ready;

  logic                   resp_valid;
  logic                   resp_hit;
  logic [INDEX_WIDTH-1:0] resp_idx;
  logic                   resp_evict;
  logic [INDEX_WIDTH:0]   occupancy;

  logic [KEY_WIDTH-1:0]   cam_lookup_key;
  logic                   cam_lookup_hit;
  logic [INDEX_WIDTH-1:0] cam_lookup_idx;
  logic                   cam_update_en;
  logic                   cam_update_valid;
  logic [KEY_WIDTH-1:0]   cam_update_key;
  logic [INDEX_WIDTH-1:0] cam_update_idx;

  modport slave (
    input  req_valid, req_op, req_key, cam_lookup_hit, cam_lookup_idx,
    output req_ready, resp_valid, resp_hit, resp_idx, resp_evict, occupancy,
    output cam_lookup_key, cam_update_en, cam_update_valid, cam_update_key, cam_update_idx
  );

  modport master (
    output req_valid, req_op, req_key, cam_lookup_hit, cam_lookup_idx,
    input  req_ready, resp_valid, resp_hit, resp_idx, resp_evict, occupancy,
    input  cam_lookup_key, cam_update_en, cam_update_valid, cam_update_key, cam_update_idx
  );
endinterface

// File: rtl/cam_alloc_ctrl.sv
// Serializes insert/invalidate/flush to a shared CAM, tracking a shadow valid vector and picking victims.
// Latency: 2 cycles for insert/invalidate, NUM_ENTRIES+1 for flush; req_ready is low while busy.
module cam_alloc_ctrl #(
  parameter int NUM_ENTRIES = 8,
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  cam_alloc_ctrl_if.slave bus
);

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_INVAL  = 2'b01;
  localparam logic [1:0] OP_FLUSH  = 2'b10;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FLUSH
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [INDEX_WIDTH-1:0] walk_q, walk_d;
  logic [INDEX_WIDTH-1:0] rr_q, rr_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [INDEX_WIDTH:0]   occ_q, occ_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_hit_q, resp_hit_d;
  logic [INDEX_WIDTH-1:0] resp_idx_q, resp_idx_d;
  logic                   resp_evict_q, resp_evict_d;

  logic                   upd_en;
  logic                   upd_valid;
  logic [KEY_WIDTH-1:0]   upd_key;
  logic [INDEX_WIDTH-1:0] upd_idx;

  logic                   free_found;
  logic [INDEX_WIDTH-1:0] free_idx;
  logic [INDEX_WIDTH-1:0] victim;

  // Scanning downward leaves the lowest free index as the final winner.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = INDEX_WIDTH'(i);
      end
    end
  end

  assign victim = free_found ? free_idx : rr_q;

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      occ_d = occ_d + (INDEX_WIDTH + 1)'(valid_d[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    walk_d       = walk_q;
    rr_d         = rr_q;
    valid_d      = valid_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_idx_d   = resp_idx_q;
    resp_evict_d = resp_evict_q;
    upd_en       = 1'b0;
    upd_valid    = 1'b0;
    upd_key      = '0;
    upd_idx      = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          key_d = bus.req_key;
          case (bus.req_op)
            OP_INSERT, OP_INVAL: state_d = S_LOOKUP;
            OP_FLUSH: begin
              state_d = S_FLUSH;
              walk_d  = '0;
            end
            default: begin
              resp_valid_d = 1'b1;
              resp_hit_d   = 1'b0;
              resp_idx_d   = '0;
              resp_evict_d = 1'b0;
            end
          endcase
        end
      end

      S_LOOKUP: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_evict_d = 1'b0;
        if (op_q == OP_INSERT) begin
          if (bus.cam_lookup_hit) begin
            resp_hit_d = 1'b1;
            resp_idx_d = bus.cam_lookup_idx;
          end else begin
            upd_en          = 1'b1;
            upd_valid       = 1'b1;
            upd_key         = key_q;
            upd_idx         = victim;
            valid_d[victim] = 1'b1;
            resp_hit_d      = 1'b0;
            resp_idx_d      = victim;
            if (!free_found) begin
              resp_evict_d = 1'b1;
              rr_d         = (rr_q == LAST_IDX) ? '0 : rr_q + 1'b1;
            end
          end
        end else begin
          if (bus.cam_lookup_hit) begin
            upd_en                      = 1'b1;
            upd_idx                     = bus.cam_lookup_idx;
            valid_d[bus.cam_lookup_idx] = 1'b0;
            resp_hit_d                  = 1'b1;
            resp_idx_d                  = bus.cam_lookup_idx;
          end else begin
            resp_hit_d = 1'b0;
            resp_idx_d = '0;
          end
        end
      end

      S_FLUSH: begin
        upd_en  = 1'b1;
        upd_idx = walk_q;
        if (walk_q == LAST_IDX) begin
          // rr_q deliberately survives the flush so eviction order stays fair.
          valid_d      = '0;
          walk_d       = '0;
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_idx_d   = '0;
          resp_evict_d = 1'b0;
        end else begin
          walk_d = walk_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      key_q        <= '0;
      walk_q       <= '0;
      rr_q         <= '0;
      valid_q      <= '0;
      occ_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= '0;
      resp_evict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_q        <= key_d;
      walk_q       <= walk_d;
      rr_q         <= rr_d;
      valid_q      <= valid_d;
      occ_q        <= occ_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_idx_q   <= resp_idx_d;
      resp_evict_q <= resp_evict_d;
    end
  end

  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_hit         = resp_hit_q;
  assign bus.resp_idx         = resp_idx_q;
  assign bus.resp_evict       = resp_evict_q;
  assign bus.occupancy        = occ_q;
  assign bus.cam_lookup_key   = key_q;
  assign bus.cam_update_en    = upd_en;
  assign bus.cam_update_valid = upd_valid;
  assign bus.cam_update_key   = upd_key;
  assign bus.cam_update_idx   = upd_idx;

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Directed bench for cam_alloc_ctrl with an 8-entry behavioural CAM behind it.
module tb_cam_alloc_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  cam_alloc_ctrl_if #(.NUM_ENTRIES(8), .KEY_WIDTH(32)) bus ();

  cam_alloc_ctrl #(.NUM_ENTRIES(8), .KEY_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM sharing the controller's reset.
  logic        cam_v [8];
  logic [31:0] cam_k [8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        cam_v[i] <= 1'b0;
        cam_k[i] <= '0;
      end
    end else if (bus.cam_update_en) begin
      cam_v[bus.cam_update_idx] <= bus.cam_update_valid;
      cam_k[bus.cam_update_idx] <= bus.cam_update_key;
    end
  end

  always_comb begin
    bus.cam_lookup_hit = 1'b0;
    bus.cam_lookup_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (cam_v[i] && cam_k[i] == bus.cam_lookup_key) begin
        bus.cam_lookup_hit = 1'b1;
        bus.cam_lookup_idx = 3'(i);
      end
    end
  end

  logic       r_hit;
  logic [2:0] r_idx;
  logic       r_evict;
  int         r_lat;
  int         r_nupd;
  logic [2:0] upd_idx_q [$];
  logic       upd_vld_q [$];

  // Called at a negedge; lat counts clock edges from the accept edge through the response.
  task automatic issue(input logic [1:0] op, input logic [31:0] key);
    int  guard;
    bit  done;
    guard  = 0;
    done   = 0;
    r_lat  = 0;
    r_nupd = 0;
    upd_idx_q.delete();
    upd_vld_q.delete();
    while (!bus.req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.cam_update_en) begin
        r_nupd++;
        upd_idx_q.push_back(bus.cam_update_idx);
        upd_vld_q.push_back(bus.cam_update_valid);
        if (bus.cam_update_valid) begin
          bit dup;
          dup = 0;
          for (int j = 0; j < 8; j++)
            if (3'(j) != bus.cam_update_idx && cam_v[j] && cam_k[j] == bus.cam_update_key) dup = 1;
          tests++;
          if (dup) begin
            fails++;
            $display("FAIL dup_key: key %h written to slot %0d while present elsewhere", bus.cam_update_key, bus.cam_update_idx);
          end
        end
      end
      if (bus.resp_valid) begin
        r_lat   = c;
        r_hit   = bus.resp_hit;
        r_idx   = bus.resp_idx;
        r_evict = bus.resp_evict;
        done    = 1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: op %0d key %h got no resp_valid within 40 cycles", op, key);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.cam_update_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: resp_valid=%b cam_update_en=%b, need 0/0", bus.resp_valid, bus.cam_update_en);
    end
    tests++;
    if (bus.occupancy !== 4'd0 || bus.resp_idx !== 3'd0 || bus.resp_hit !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: occ=%0d idx=%0d hit=%b, need 0/0/0", bus.occupancy, bus.resp_idx, bus.resp_hit);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b, need 1", bus.req_ready);
    end
  endtask

  task automatic test_insert_first();
    issue(2'b00, 32'h1000);
    tests++;
    if (r_lat != 2 || r_hit !== 1'b0 || r_idx !== 3'd0 || r_evict !== 1'b0) begin
      fails++;
      $display("FAIL insert_first: lat=%0d hit=%b idx=%0d ev=%b, need 2/0/0/0", r_lat, r_hit, r_idx, r_evict);
    end
    tests++;
    if (bus.occupancy !== 4'd1 || r_nupd != 1 || !(cam_v[0] === 1'b1 && cam_k[0] === 32'h1000)) begin
      fails++;
      $display("FAIL insert_first_cam: occ=%0d nupd=%0d slot0=%b/%h, need 1/1/1/1000", bus.occupancy, r_nupd, cam_v[0], cam_k[0]);
    end
  endtask

  task automatic test_duplicate();
    issue(2'b00, 32'h1000);
    tests++;
    if (r_hit !== 1'b1 || r_idx !== 3'd0 || r_nupd != 0 || bus.occupancy !== 4'd1) begin
      fails++;
      $display("FAIL insert_dup: hit=%b idx=%0d nupd=%0d occ=%0d, need 1/0/0/1", r_hit, r_idx, r_nupd, bus.occupancy);
    end
  endtask

  task automatic test_fill_evict();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      issue(2'b00, 32'(k * 16));
      tests++;
      if (r_hit !== 1'b0 || r_idx !== 3'(k - 1) || r_evict !== 1'b0) begin
        fails++;
        $display("FAIL fill_%0d: hit=%b idx=%0d ev=%b, need 0/%0d/0", k, r_hit, r_idx, r_evict, k - 1);
      end
    end
    tests++;
    if (bus.occupancy !== 4'd8) begin
      fails++;
      $display("FAIL fill_occ: occ=%0d, need 8", bus.occupancy);
    end
    issue(2'b00, 32'h90);
    tests++;
    if (r_idx !== 3'd0 || r_evict !== 1'b1 || bus.occupancy !== 4'd8) begin
      fails++;
      $display("FAIL evict_90: idx=%0d ev=%b occ=%0d, need 0/1/8", r_idx, r_evict, bus.occupancy);
    end
    issue(2'b00, 32'hA0);
    tests++;
    if (r_idx !== 3'd1 || r_evict !== 1'b1) begin
      fails++;
      $display("FAIL evict_A0: idx=%0d ev=%b, need 1/1", r_idx, r_evict);
    end
    issue(2'b01, 32'h10);
    tests++;
    if (r_hit !== 1'b0 || r_idx !== 3'd0 || r_nupd != 0) begin
      fails++;
      $display("FAIL evicted_10_miss: hit=%b idx=%0d nupd=%0d, need 0/0/0", r_hit, r_idx, r_nupd);
    end
  endtask

  task automatic test_invalidate();
    issue(2'b01, 32'h30);
    tests++;
    if (r_hit !== 1'b1 || r_idx !== 3'd2 || bus.occupancy !== 4'd7 || r_nupd != 1 || upd_vld_q[0] !== 1'b0) begin
      fails++;
      $display("FAIL inval_30: hit=%b idx=%0d occ=%0d nupd=%0d, need 1/2/7/1 with valid=0", r_hit, r_idx, bus.occupancy, r_nupd);
    end
    issue(2'b00, 32'hB0);
    tests++;
    if (r_idx !== 3'd2 || r_evict !== 1'b0 || bus.occupancy !== 4'd8) begin
      fails++;
      $display("FAIL refill_B0: idx=%0d ev=%b occ=%0d, need 2/0/8", r_idx, r_evict, bus.occupancy);
    end
  endtask

  task automatic test_back_to_back();
    // Table full, rr pointer at 2: 0xC0 evicts slot 2, then is found there.
    issue(2'b00, 32'hC0);
    tests++;
    if (r_idx !== 3'd2 || r_evict !== 1'b1 || r_lat != 2) begin
      fails++;
      $display("FAIL b2b_first: idx=%0d ev=%b lat=%0d, need 2/1/2", r_idx, r_evict, r_lat);
    end
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready: req_ready=%b during resp, need 1", bus.req_ready);
    end
    issue(2'b00, 32'hC0);
    tests++;
    if (r_hit !== 1'b1 || r_idx !== 3'd2 || r_lat != 2 || r_nupd != 0) begin
      fails++;
      $display("FAIL b2b_second: hit=%b idx=%0d lat=%0d nupd=%0d, need 1/2/2/0", r_hit, r_idx, r_lat, r_nupd);
    end
  endtask

  task automatic test_flush();
    bit any_valid;
    issue(2'b10, 32'h0);
    tests++;
    if (r_nupd != 8 || r_lat != 9 || r_hit !== 1'b0 || bus.occupancy !== 4'd0) begin
      fails++;
      $display("FAIL flush_resp: nupd=%0d lat=%0d hit=%b occ=%0d, need 8/9/0/0", r_nupd, r_lat, r_hit, bus.occupancy);
    end
    for (int i = 0; i < 8 && i < r_nupd; i++) begin
      tests++;
      if (upd_idx_q[i] !== 3'(i) || upd_vld_q[i] !== 1'b0) begin
        fails++;
        $display("FAIL flush_walk_%0d: idx=%0d valid=%b, need %0d/0", i, upd_idx_q[i], upd_vld_q[i], i);
      end
    end
    any_valid = 0;
    for (int i = 0; i < 8; i++) any_valid |= cam_v[i];
    tests++;
    if (any_valid) begin
      fails++;
      $display("FAIL flush_cam_empty: a CAM slot is still valid, need none");
    end
    issue(2'b01, 32'h40);
    tests++;
    if (r_hit !== 1'b0) begin
      fails++;
      $display("FAIL flush_lookup: hit=%b for 0x40, need 0", r_hit);
    end
    // Eviction pointer (3) survives the flush.
    for (int k = 1; k <= 8; k++) issue(2'b00, 32'(k * 256));
    issue(2'b00, 32'h900);
    tests++;
    if (r_idx !== 3'd3 || r_evict !== 1'b1) begin
      fails++;
      $display("FAIL flush_keeps_rr: idx=%0d ev=%b, need 3/1", r_idx, r_evict);
    end
  endtask

  task automatic test_reset_mid_flush();
    bit hit3;
    int seen;
    hit3 = 0;
    seen = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    for (int c = 0; c < 20 && !hit3; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.cam_update_en && bus.cam_update_idx == 3'd3) hit3 = 1;
    end
    tests++;
    if (!hit3) begin
      fails++;
      $display("FAIL flush_reach_3: update idx 3 never seen, need it");
    end
    reset = 1'b1;
    #1;
    tests++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.occupancy !== 4'd0 || bus.cam_update_en !== 1'b0) begin
      fails++;
      $display("FAIL midflush_reset: rv=%b rdy=%b occ=%0d upd=%b, need 0/1/0/0", bus.resp_valid, bus.req_ready, bus.occupancy, bus.cam_update_en);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.cam_update_en) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL midflush_quiet: %0d cycles with resp_valid/update after reset, need 0", seen);
    end
  endtask

  task automatic test_reserved();
    issue(2'b00, 32'h11);
    issue(2'b00, 32'h22);
    tests++;
    if (r_idx !== 3'd1 || bus.occupancy !== 4'd2) begin
      fails++;
      $display("FAIL reserved_setup: idx=%0d occ=%0d, need 1/2", r_idx, bus.occupancy);
    end
    issue(2'b11, 32'h22);
    tests++;
    if (r_lat != 1 || r_hit !== 1'b0 || r_idx !== 3'd0 || r_evict !== 1'b0 || r_nupd != 0) begin
      fails++;
      $display("FAIL reserved_op: lat=%0d hit=%b idx=%0d ev=%b nupd=%0d, need 1/0/0/0/0", r_lat, r_hit, r_idx, r_evict, r_nupd);
    end
    tests++;
    if (bus.occupancy !== 4'd2) begin
      fails++;
      $display("FAIL reserved_occ: occ=%0d, need 2", bus.occupancy);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_key   = '0;
    @(negedge clk);
    test_reset();
    test_insert_first();
    test_duplicate();
    test_fill_evict();
    test_invalidate();
    test_back_to_back();
    test_flush();
    test_reset_mid_flush();
    test_reserved();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
